// File: rtl/wb_qspi_arb.sv
// Two-master Wishbone arbiter and region decoder in front of the QSPI memory adapter.
// Illegal accesses (unmapped, or dbus write to ROM) are answered locally with err.
module wb_qspi_arb #(
    parameter logic [7:0] ROM_TAG = 8'h00,
    parameter logic [7:0] RAM_TAG = 8'h01
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_stb_i,
    input  logic [29:0] i_adr_i,
    output logic        i_ack_o,
    output logic        i_err_o,
    output logic [31:0] i_dat_o,
    input  logic        d_stb_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_be_i,
    input  logic [29:0] d_adr_i,
    input  logic [31:0] d_dat_i,
    output logic        d_ack_o,
    output logic        d_err_o,
    output logic [31:0] d_dat_o,
    output logic        mem_sel_rom_ram_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [21:0] mem_adr_o,
    output logic [31:0] mem_dat_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_dat_i
);

    localparam int unsigned TAG_W = 8;
    localparam int unsigned MEM_AW = 22;
    localparam int unsigned DW = 32;
    localparam int unsigned BEW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GNT_I,
        S_GNT_D,
        S_ERR_I,
        S_ERR_D
    } state_e;

    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   sel_q, sel_d;

    logic [TAG_W-1:0] i_tag, d_tag;
    logic             i_is_rom, i_is_ram, i_legal;
    logic             d_is_rom, d_is_ram, d_legal;
    logic             d_wins;

    // Region decode of both requesters; writes to ROM are treated as illegal.
    always_comb begin
        i_tag    = i_adr_i[29:22];
        d_tag    = d_adr_i[29:22];
        i_is_rom = (i_tag == ROM_TAG);
        i_is_ram = (i_tag == RAM_TAG);
        d_is_rom = (d_tag == ROM_TAG);
        d_is_ram = (d_tag == RAM_TAG);
        i_legal  = i_is_rom | i_is_ram;
        d_legal  = d_is_ram | (d_is_rom & ~d_we_i);
        // On a tie the master that was not served last wins.
        d_wins   = d_stb_i & (~i_stb_i | (last_q == LAST_I));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            last_q  <= LAST_I;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state: arbitration in IDLE, grants held until the adapter acks.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (d_wins) begin
                    last_d = LAST_D;
                    if (d_legal) begin
                        state_d = S_GNT_D;
                        sel_d   = d_is_ram;
                    end else begin
                        state_d = S_ERR_D;
                    end
                end else if (i_stb_i) begin
                    last_d = LAST_I;
                    if (i_legal) begin
                        state_d = S_GNT_I;
                        sel_d   = i_is_ram;
                    end else begin
                        state_d = S_ERR_I;
                    end
                end
            end
            S_GNT_I, S_GNT_D: begin
                if (mem_ack_i) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR_I, S_ERR_D: state_d = S_IDLE;
            default:          state_d = S_IDLE;
        endcase
    end

    // Adapter-side mux and master responses, all derived from the state register.
    always_comb begin
        mem_stb_o = 1'b0;
        mem_we_o  = 1'b0;
        mem_be_o  = d_be_i;
        mem_adr_o = d_adr_i[MEM_AW-1:0];
        mem_dat_o = d_dat_i;
        i_ack_o   = 1'b0;
        i_err_o   = 1'b0;
        d_ack_o   = 1'b0;
        d_err_o   = 1'b0;
        case (state_q)
            S_GNT_I: begin
                mem_stb_o = 1'b1;
                mem_be_o  = {BEW{1'b1}};
                mem_adr_o = i_adr_i[MEM_AW-1:0];
                mem_dat_o = DW'(0);
                i_ack_o   = mem_ack_i;
            end
            S_GNT_D: begin
                mem_stb_o = 1'b1;
                mem_we_o  = d_we_i;
                d_ack_o   = mem_ack_i;
            end
            S_ERR_I: i_err_o = 1'b1;
            S_ERR_D: d_err_o = 1'b1;
            default: ;
        endcase
    end

    assign mem_sel_rom_ram_o = sel_q;
    assign i_dat_o           = mem_dat_i;
    assign d_dat_o           = mem_dat_i;

endmodule

// File: tb/tb_wb_qspi_arb.sv
// Bench for wb_qspi_arb: directed scenarios plus randomized Wishbone traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_wb_qspi_arb;

    localparam logic [7:0] ROM_T = 8'h00;
    localparam logic [7:0] RAM_T = 8'h01;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        i_stb_i;
    logic [29:0] i_adr_i;
    logic        i_ack_o, i_err_o;
    logic [31:0] i_dat_o;
    logic        d_stb_i, d_we_i;
    logic [3:0]  d_be_i;
    logic [29:0] d_adr_i;
    logic [31:0] d_dat_i;
    logic        d_ack_o, d_err_o;
    logic [31:0] d_dat_o;
    logic        mem_sel_rom_ram_o, mem_stb_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [21:0] mem_adr_o;
    logic [31:0] mem_dat_o;
    logic        mem_ack_i;
    logic [31:0] mem_dat_i;

    wb_qspi_arb #(.ROM_TAG(ROM_T), .RAM_TAG(RAM_T)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .i_stb_i(i_stb_i), .i_adr_i(i_adr_i), .i_ack_o(i_ack_o), .i_err_o(i_err_o), .i_dat_o(i_dat_o),
        .d_stb_i(d_stb_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_adr_i(d_adr_i), .d_dat_i(d_dat_i),
        .d_ack_o(d_ack_o), .d_err_o(d_err_o), .d_dat_o(d_dat_o),
        .mem_sel_rom_ram_o(mem_sel_rom_ram_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o),
        .mem_ack_i(mem_ack_i), .mem_dat_i(mem_dat_i)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who owns the adapter (0 none, 1 ibus, 2 dbus), who gets an err
    // this cycle, who was served last, and the ROM/RAM select.
    int m_owner, m_err, m_last;
    logic m_sel;
    bit i_done, d_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int region(input logic [29:0] a);
        if (a[29:22] == ROM_T) return 0;
        if (a[29:22] == RAM_T) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_err = 0; m_last = 1; m_sel = 1'b0;
        i_done = 1'b0; d_done = 1'b0;
    endtask

    // What happens at the coming rising edge, given the current inputs.
    task automatic model_update();
        int w, r;
        bit legal;
        if (m_owner != 0) begin
            if (mem_ack_i) m_owner = 0;
        end else if (m_err != 0) begin
            m_err = 0;
        end else begin
            w = 0;
            if (i_stb_i && d_stb_i) w = (m_last == 1) ? 2 : 1;
            else if (i_stb_i)       w = 1;
            else if (d_stb_i)       w = 2;
            if (w != 0) begin
                r = (w == 1) ? region(i_adr_i) : region(d_adr_i);
                legal = (r != 2) && !(w == 2 && d_we_i && r == 0);
                if (legal) begin
                    m_owner = w;
                    m_sel   = (r == 1);
                end else begin
                    m_err = w;
                end
                m_last = w;
            end
        end
    endtask

    // Compare every DUT output against the model, shortly after inputs change.
    task automatic settle();
        #1;
        chk("mem_stb", 32'(mem_stb_o), 32'(m_owner != 0));
        chk("mem_we", 32'(mem_we_o), 32'(m_owner == 2 && d_we_i));
        chk("mem_sel", 32'(mem_sel_rom_ram_o), 32'(m_sel));
        chk("i_ack", 32'(i_ack_o), 32'(m_owner == 1 && mem_ack_i));
        chk("d_ack", 32'(d_ack_o), 32'(m_owner == 2 && mem_ack_i));
        chk("i_err", 32'(i_err_o), 32'(m_err == 1));
        chk("d_err", 32'(d_err_o), 32'(m_err == 2));
        chk("i_dat", i_dat_o, mem_dat_i);
        chk("d_dat", d_dat_o, mem_dat_i);
        if (m_owner == 1) begin
            chk("mem_adr_i", 32'(mem_adr_o), 32'(i_adr_i[21:0]));
            chk("mem_be_i", 32'(mem_be_o), 32'hF);
            chk("mem_dat_i", mem_dat_o, 32'h0);
        end else if (m_owner == 2) begin
            chk("mem_adr_d", 32'(mem_adr_o), 32'(d_adr_i[21:0]));
            chk("mem_be_d", 32'(mem_be_o), 32'(d_be_i));
            chk("mem_dat_d", mem_dat_o, d_dat_i);
        end
        i_done = (m_owner == 1 && mem_ack_i) || m_err == 1;
        d_done = (m_owner == 2 && mem_ack_i) || m_err == 2;
    endtask

    task automatic adv();
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_stb_i = 1'b0; i_adr_i = '0;
        d_stb_i = 1'b0; d_we_i = 1'b0; d_be_i = '0; d_adr_i = '0; d_dat_i = '0;
        mem_ack_i = 1'b0; mem_dat_i = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        idle_inputs();
        #1;
        chk("rst_stb", 32'(mem_stb_o), 32'h0);
        chk("rst_we", 32'(mem_we_o), 32'h0);
        chk("rst_sel", 32'(mem_sel_rom_ram_o), 32'h0);
        chk("rst_acks", 32'({i_ack_o, d_ack_o}), 32'h0);
        chk("rst_errs", 32'({i_err_o, d_err_o}), 32'h0);
        @(negedge clk);
        rst_i = 1'b0;
        model_reset();
    endtask

    function automatic logic [29:0] rand_adr();
        logic [7:0] t;
        case ($urandom_range(0, 3))
            0:       t = ROM_T;
            1, 2:    t = RAM_T;
            default: t = 8'($urandom);
        endcase
        return {t, 22'($urandom)};
    endfunction

    initial begin
        int g, who;
        rst_i = 1'b1;
        idle_inputs();
        model_reset();
        do_reset();

        // ibus ROM read, adapter answers DEADBEEF
        i_stb_i = 1'b1; i_adr_i = {8'h00, 22'h000010};
        settle(); adv();
        settle();
        chk("t1_stb", 32'(mem_stb_o), 32'h1);
        chk("t1_sel", 32'(mem_sel_rom_ram_o), 32'h0);
        chk("t1_adr", 32'(mem_adr_o), 32'h10);
        chk("t1_we", 32'(mem_we_o), 32'h0);
        chk("t1_be", 32'(mem_be_o), 32'hF);
        mem_ack_i = 1'b1; mem_dat_i = 32'hDEADBEEF;
        settle();
        chk("t1_ack", 32'(i_ack_o), 32'h1);
        chk("t1_dat", i_dat_o, 32'hDEADBEEF);
        adv();
        i_stb_i = 1'b0; mem_ack_i = 1'b0;

        // dbus byte write to RAM, two wait cycles before the ack
        d_stb_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0100;
        d_adr_i = {8'h01, 22'h000123}; d_dat_i = 32'h00AB0000;
        settle(); adv();
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("t2_sel", 32'(mem_sel_rom_ram_o), 32'h1);
            chk("t2_we", 32'(mem_we_o), 32'h1);
            chk("t2_be", 32'(mem_be_o), 32'h4);
            chk("t2_noack", 32'({i_ack_o, d_ack_o}), 32'h0);
            adv();
        end
        mem_ack_i = 1'b1;
        settle();
        chk("t2_ack", 32'({i_ack_o, d_ack_o}), 32'h1);
        adv();
        idle_inputs();

        // Both masters requesting from reset: D first, then alternate
        do_reset();
        i_stb_i = 1'b1; i_adr_i = {8'h00, 22'h000040};
        d_stb_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_adr_i = {8'h01, 22'h000080};
        g = 0;
        for (int k = 0; k < 12; k++) begin
            mem_ack_i = (m_owner != 0);
            settle();
            if (i_ack_o || d_ack_o) begin
                who = d_ack_o ? 2 : 1;
                chk("t3_rr_order", 32'(who), (g % 2 == 0) ? 32'd2 : 32'd1);
                g++;
            end
            adv();
        end
        chk("t3_rr_count", 32'(g), 32'd6);
        idle_inputs();
        settle(); adv();

        // dbus write to ROM and ibus to unmapped tag: one-cycle err, no strobe
        d_stb_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'hF; d_adr_i = {8'h00, 22'h000004};
        settle(); adv();
        settle();
        chk("t4_derr", 32'(d_err_o), 32'h1);
        chk("t4_dstb", 32'(mem_stb_o), 32'h0);
        d_stb_i = 1'b0;
        adv();
        settle();
        chk("t4_derr_once", 32'(d_err_o), 32'h0);
        i_stb_i = 1'b1; i_adr_i = {8'h7F, 22'h000004};
        settle(); adv();
        settle();
        chk("t4_ierr", 32'(i_err_o), 32'h1);
        chk("t4_istb", 32'(mem_stb_o), 32'h0);
        i_stb_i = 1'b0;
        adv();
        settle();
        chk("t4_ierr_once", 32'(i_err_o), 32'h0);
        adv();

        // Long GNT_D stall while ibus waits
        d_stb_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_adr_i = {8'h01, 22'h2AAAAA};
        i_stb_i = 1'b1; i_adr_i = {8'h00, 22'h000100};
        settle(); adv();
        for (int k = 0; k < 40; k++) begin
            settle();
            chk("t5_hold_adr", 32'(mem_adr_o), 32'h2AAAAA);
            chk("t5_hold_sel", 32'(mem_sel_rom_ram_o), 32'h1);
            chk("t5_no_iack", 32'(i_ack_o), 32'h0);
            adv();
        end
        mem_ack_i = 1'b1;
        settle();
        chk("t5_dack", 32'(d_ack_o), 32'h1);
        adv();
        d_stb_i = 1'b0; mem_ack_i = 1'b0;
        settle(); adv();
        settle();
        chk("t5_igrant_stb", 32'(mem_stb_o), 32'h1);
        chk("t5_igrant_adr", 32'(mem_adr_o), 32'h100);
        chk("t5_igrant_sel", 32'(mem_sel_rom_ram_o), 32'h0);
        mem_ack_i = 1'b1;
        settle(); adv();
        idle_inputs();

        // Reset in the middle of an ibus grant
        i_stb_i = 1'b1; i_adr_i = {8'h01, 22'h000008};
        settle(); adv();
        settle();
        #2;
        rst_i = 1'b1;
        #1;
        chk("t6_rst_stb", 32'(mem_stb_o), 32'h0);
        chk("t6_rst_ack", 32'(i_ack_o), 32'h0);
        @(negedge clk);
        i_stb_i = 1'b0;
        rst_i = 1'b0;
        model_reset();
        d_stb_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_adr_i = {8'h01, 22'h000020};
        settle(); adv();
        settle();
        chk("t6_d_stb", 32'(mem_stb_o), 32'h1);
        chk("t6_d_adr", 32'(mem_adr_o), 32'h20);
        mem_ack_i = 1'b1; mem_dat_i = 32'h12345678;
        settle();
        chk("t6_d_ack", 32'(d_ack_o), 32'h1);
        chk("t6_d_dat", d_dat_o, 32'h12345678);
        adv();
        idle_inputs();

        // Randomized traffic
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (!i_stb_i || i_done) begin
                i_stb_i = ($urandom_range(0, 2) != 0);
                i_adr_i = rand_adr();
            end
            if (!d_stb_i || d_done) begin
                d_stb_i = ($urandom_range(0, 2) != 0);
                d_we_i  = 1'($urandom);
                d_be_i  = 4'($urandom);
                d_adr_i = rand_adr();
                d_dat_i = $urandom;
            end
            mem_ack_i = (m_owner != 0) && ($urandom_range(0, 3) == 0);
            mem_dat_i = $urandom;
            settle();
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
